regbank8x16_wr: RTL

Write side of the 8-entry × 16-bit register bank. Decodes a 3-bit write select into one of eight 16-bit storage words, with per-byte write enables. Flattens all eight words onto a 128-bit bus: word k occupies bits [16k+15:16k]. That bus feeds the 8-to-1 16-bit read muxes directly. Also keeps a per-entry "written since clear" bitmap and flags malformed write requests.

---
 rtl/regbank8x16_wr_pkg.sv | 25 ++
 rtl/regbank8x16_wr_dff16_be.sv | 32 +++
 rtl/regbank8x16_wr.sv | 95 +++++++++
 3 files changed

// File: rtl/regbank8x16_wr_pkg.sv
// Shared constants and helpers for the 8x16 register bank write side.
package regbank8x16_wr_pkg;

    localparam int RB_NENT = 8;
    localparam int RB_W    = 16;
    localparam int RB_SELW = 3;

    localparam logic [1:0] BE_LO  = 2'b01;
    localparam logic [1:0] BE_HI  = 2'b10;
    localparam logic [1:0] BE_ALL = 2'b11;

    // Expand the 2-bit byte enable into a 16-bit lane mask.
    function automatic logic [RB_W-1:0] lane_mask(input logic [1:0] be);
        logic [RB_W-1:0] m;
        m = 16'h0000;
        if ((be & BE_LO) != 2'b00) begin
            m = m | 16'h00FF;
        end
        if ((be & BE_HI) != 2'b00) begin
            m = m | 16'hFF00;
        end
        return m;
    endfunction

endpackage

// File: rtl/regbank8x16_wr_dff16_be.sv
// 16-bit storage word: async active-low reset, synchronous clear, byte-enabled write.
// Clear is applied before the write, so enabled lanes take data and disabled lanes read 0.
module dff16_be
    import regbank8x16_wr_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            srst,
    input  logic            we,
    input  logic [1:0]      be,
    input  logic [RB_W-1:0] d,
    output logic [RB_W-1:0] q
);

    logic [RB_W-1:0] wmask_s;
    logic [RB_W-1:0] keep_s;
    logic [RB_W-1:0] next_s;

    assign wmask_s = we ? lane_mask(be) : 16'h0000;
    assign keep_s  = srst ? 16'h0000 : q;
    assign next_s  = (d & wmask_s) | (keep_s & ~wmask_s);

    // Word storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 16'h0000;
        end else begin
            q <= next_s;
        end
    end

endmodule

// File: rtl/regbank8x16_wr.sv
// Write side of the 8-entry x 16-bit register bank: select decode, byte-lane
// storage words, written-since-clear bitmap and malformed-request flag.
module regbank8x16_wr
    import regbank8x16_wr_pkg::*;
#(
    parameter int N_ENT = RB_NENT,
    parameter int W     = RB_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [RB_SELW-1:0]   wr_sel,
    input  logic [1:0]           wr_be,
    input  logic [W-1:0]         wr_data,
    input  logic                 clr,
    output logic [N_ENT*W-1:0]   regs_flat,
    output logic [N_ENT-1:0]     ent_vld,
    output logic                 wr_err
);

    // Goes high on the first edge after reset release; the write on the
    // release edge itself is therefore ignored.
    logic             arm_r;
    logic             xz_s;
    logic             req_s;
    logic             be_any_s;
    logic [N_ENT-1:0] dec_s;
    logic [N_ENT-1:0] vld_nxt_s;
    logic             err_nxt_s;

`ifndef SYNTHESIS
    assign xz_s = $isunknown({wr_sel, wr_be});
`else
    assign xz_s = 1'b0;
`endif

    assign req_s    = wr_en & arm_r;
    assign be_any_s = ((wr_be & BE_ALL) != 2'b00);

    // Arm write acceptance one edge after reset deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_r <= 1'b0;
        end else begin
            arm_r <= 1'b1;
        end
    end

    // One-hot decode of the write select; a request with unknown fields writes nothing.
    always_comb begin
        dec_s = 8'h00;
        if (req_s && !xz_s) begin
            dec_s = 8'h01 << wr_sel;
        end else begin
            dec_s = 8'h00;
        end
    end

    // Next valid bitmap: clear first, then mark the entry actually written.
    always_comb begin
        vld_nxt_s = clr ? 8'h00 : ent_vld;
        if (be_any_s) begin
            vld_nxt_s = vld_nxt_s | dec_s;
        end else begin
            vld_nxt_s = vld_nxt_s;
        end
    end

    // Empty byte enable or unknown select/enable is a malformed request.
    assign err_nxt_s = req_s & (xz_s | ~be_any_s);

    // Valid bitmap and single-cycle error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= 8'h00;
            wr_err  <= 1'b0;
        end else begin
            ent_vld <= vld_nxt_s;
            wr_err  <= err_nxt_s;
        end
    end

    for (genvar k = 0; k < N_ENT; k++) begin : g_word
        dff16_be u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .srst  (clr),
            .we    (dec_s[k]),
            .be    (wr_be),
            .d     (wr_data),
            .q     (regs_flat[k*W +: W])
        );
    end

endmodule
